// File: rtl/alu_pkg.sv
// Shared ALU control codes and multiplier sequencer state encoding.
// Latency: n/a (declarations only). Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/result and shared-ALU signals of the shift-add multiplier.
// Latency: n/a (wiring only). Backpressure: start is dropped unless the sequencer is idle.
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_hi;
    logic [WIDTH-1:0] product_lo;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    // Sequencer side.
    modport slave (
        input  start, multiplicand, multiplier, alu_result, alu_carry,
        output busy, done, product_hi, product_lo, alu_a, alu_b, alu_ctrl
    );

    // Execute-stage side: issues requests and provides the ALU.
    modport master (
        output start, multiplicand, multiplier, alu_result, alu_carry,
        input  busy, done, product_hi, product_lo, alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned shift-add multiplier driving the shared ALU as its adder; WIDTH RUN cycles, done WIDTH+1 after start.
// Backpressure: none; start is only honoured in IDLE, otherwise dropped.
import alu_pkg::*;

module alu_mul_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    alu_mul_sequencer_if.slave bus
);

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
    logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             busy;
    logic             done;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        prod_hi_d = prod_hi_q;
        prod_lo_d = prod_lo_q;
        cnt_d     = cnt_q;
        busy      = 1'b0;
        done      = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = ALU_AND;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d   = bus.multiplicand;
                    prod_hi_d = '0;
                    prod_lo_d = bus.multiplier;
                    cnt_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                alu_ctrl = ALU_ADD;
                alu_a    = prod_hi_q;
                alu_b    = prod_lo_q[0] ? mcand_q : '0;
                // Shift the 2*WIDTH+1 bit {carry, sum, lo} right by one; carry lands in the top bit.
                prod_hi_d = {bus.alu_carry, bus.alu_result[WIDTH-1:1]};
                prod_lo_d = {bus.alu_result[0], prod_lo_q[WIDTH-1:1]};
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.product_hi = prod_hi_q;
    assign bus.product_lo = prod_lo_q;
    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.alu_ctrl   = alu_ctrl;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer: directed plan items plus randomized operands and stray starts.
// Expected products come from plain 128-bit multiplication; timing from the accept edge.
module tb_alu_mul_sequencer;

    localparam int WIDTH = 64;
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_ADD = 4'b0010;

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        int                 acc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    int   model_free;
    logic [2*WIDTH-1:0] hold_val;
    exp_t sb_q[$];

    alu_mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Combinational stand-in for the execute-stage ALU.
    always_comb begin
        bus.alu_result = '0;
        bus.alu_carry  = 1'b0;
        case (bus.alu_ctrl)
            CTRL_ADD: {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            CTRL_AND: bus.alu_result = bus.alu_a & bus.alu_b;
            default:  bus.alu_result = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d required < limit", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input logic ok, input string name,
                         input logic [2*WIDTH-1:0] act, input logic [2*WIDTH-1:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual 0x%0h required 0x%0h", name, cyc, act, req);
        end
    endtask

    // Monitor: derives busy/done/ALU expectations from the oldest outstanding request.
    always @(negedge clk) begin
        logic exp_busy;
        logic exp_done;
        logic [2*WIDTH-1:0] got;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        got = {bus.product_hi, bus.product_lo};
        if (sb_q.size() > 0) begin
            exp_busy = (cyc >= sb_q[0].acc) && (cyc <= sb_q[0].acc + WIDTH - 1);
            exp_done = (cyc == sb_q[0].acc + WIDTH);
        end
        check(bus.busy == exp_busy, "busy", 128'(bus.busy), 128'(exp_busy));
        check(bus.done == exp_done, "done", 128'(bus.done), 128'(exp_done));
        if (exp_busy) begin
            check(bus.alu_ctrl == CTRL_ADD, "alu_ctrl_run", 128'(bus.alu_ctrl), 128'(CTRL_ADD));
        end else begin
            check(bus.alu_ctrl == CTRL_AND && bus.alu_a == '0 && bus.alu_b == '0, "alu_idle",
                  {64'(bus.alu_ctrl), bus.alu_a | bus.alu_b}, {64'(CTRL_AND), 64'd0});
        end
        if (exp_done) begin
            check(got == sb_q[0].prod, "product", got, sb_q[0].prod);
            hold_val = sb_q[0].prod;
            void'(sb_q.pop_front());
        end else if (!exp_busy) begin
            check(got == hold_val, "product_hold", got, hold_val);
        end
    end

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int e;
        exp_t x;
        @(posedge clk);
        #1;
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        e = cyc + 1;
        if (e >= model_free) begin
            x.prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            x.acc  = e;
            sb_q.push_back(x);
            model_free = e + WIDTH + 2;
        end
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.multiplicand = {$urandom, $urandom};
        bus.multiplier   = {$urandom, $urandom};
    endtask

    task automatic wait_free();
        while (cyc + 1 < model_free) @(posedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(posedge clk);
    endtask

    function automatic logic [WIDTH-1:0] rand_op();
        logic [WIDTH-1:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = '1;
            2: v = WIDTH'($urandom_range(0, 15));
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        int acc0;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        checks           = 0;
        errors           = 0;
        cyc              = 0;
        model_free       = 0;
        hold_val         = '0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        check(bus.busy == 1'b0 && bus.done == 1'b0, "reset_flags", 128'({bus.busy, bus.done}), 128'd0);
        check({bus.product_hi, bus.product_lo} == '0, "reset_product",
              {bus.product_hi, bus.product_lo}, '0);
        reset = 1'b0;

        issue(64'd3, 64'd5);
        wait_free();
        issue('1, '1);
        wait_free();
        issue(64'd0, 64'hDEAD_BEEF);
        wait_free();

        // Stray start mid-run must be dropped and leave the result intact.
        issue(64'd7, 64'd9);
        acc0 = sb_q[sb_q.size()-1].acc;
        wait_cyc(acc0 + 9);
        issue(64'd2, 64'd2);
        wait_free();

        // Asynchronous reset mid-operation abandons the request.
        issue(64'h1234, 64'h10);
        acc0 = sb_q[sb_q.size()-1].acc;
        wait_cyc(acc0 + 29);
        #2;
        reset = 1'b1;
        sb_q.delete();
        model_free = 0;
        hold_val   = '0;
        #1;
        check(bus.busy == 1'b0 && bus.done == 1'b0, "midreset_flags", 128'({bus.busy, bus.done}), 128'd0);
        check({bus.product_hi, bus.product_lo} == '0, "midreset_product",
              {bus.product_hi, bus.product_lo}, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(64'd6, 64'd7);
        wait_free();

        // Back-to-back: second start lands in the cycle right after done.
        issue(64'd2, 64'd3);
        wait_free();
        issue(64'd4, 64'd5);
        wait_free();

        for (int i = 0; i < 20; i++) begin
            a = rand_op();
            b = rand_op();
            issue(a, b);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, WIDTH + 3)) @(posedge clk);
                issue(rand_op(), rand_op());
            end
            wait_free();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        for (int t = 0; t < 200 && sb_q.size() > 0; t++) @(posedge clk);
        check(sb_q.size() == 0, "drain", 128'(sb_q.size()), 128'd0);
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
